data_mem_stage: RTL

- Data-memory stage of the pipelined MIPS datapath, sitting between the M-stage ALU result and the W-stage load extender.
- Performs word, halfword and byte stores with byte-enable merging into a word-addressed RAM.
- Reads the addressed word for loads and registers it, together with the byte offset and extend opcode, into the M/W boundary.
- W-stage outputs (ReadData_W, A_W, MemExtOp_W) feed the load extender directly.

---
 rtl/data_mem_stage_if.sv | 26 ++
 rtl/data_mem_stage.sv | 112 +++++++++++
 2 files changed

// File: rtl/data_mem_stage_if.sv
// M-stage bus of the data-memory stage: store/load request in, byte enables, error flag and the
// registered M/W word out.
interface data_mem_stage_if;
    logic        en;
    logic [31:0] Addr_M;
    logic [31:0] WriteData_M;
    logic        MemWrite_M;
    logic        MemRead_M;
    logic [1:0]  StoreOp_M;
    logic [2:0]  MemExtOp_M;
    logic [3:0]  BE_M;
    logic        AddrErr_M;
    logic [31:0] ReadData_W;
    logic [1:0]  A_W;
    logic [2:0]  MemExtOp_W;

    modport master (
        output en, Addr_M, WriteData_M, MemWrite_M, MemRead_M, StoreOp_M, MemExtOp_M,
        input  BE_M, AddrErr_M, ReadData_W, A_W, MemExtOp_W
    );

    modport slave (
        input  en, Addr_M, WriteData_M, MemWrite_M, MemRead_M, StoreOp_M, MemExtOp_M,
        output BE_M, AddrErr_M, ReadData_W, A_W, MemExtOp_W
    );
endinterface

// File: rtl/data_mem_stage.sv
// MIPS data-memory stage: byte-enable merged stores into a word RAM, combinational read in M,
// registered raw word plus byte offset and extend opcode at the M/W boundary.
module data_mem_stage #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic            clk,
    input logic            reset,
    data_mem_stage_if.slave bus
);
    localparam int unsigned Words = 1 << ADDR_W;

    logic [31:0]       mem [Words];
    logic [31:0]       offset;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        byteOff;
    logic              inRange;
    logic              misaligned;
    logic              addrErr;
    logic [3:0]        beRaw;
    logic [3:0]        be;
    logic [31:0]       laneData;
    logic [31:0]       readWord;

    assign offset  = bus.Addr_M - BASE_ADDR;
    assign idx     = offset[ADDR_W+1:2];
    assign byteOff = bus.Addr_M[1:0];
    // Unsigned difference, so addresses below BASE_ADDR wrap high and fall out of range.
    assign inRange = (offset >> (ADDR_W + 2)) == 32'd0;

    always_comb begin
        misaligned = 1'b0;
        if (bus.MemWrite_M) begin
            case (bus.StoreOp_M)
                2'd0:    if (byteOff != 2'd0) misaligned = 1'b1;
                2'd1:    if (byteOff[0]) misaligned = 1'b1;
                default: ;
            endcase
        end
        if (bus.MemRead_M) begin
            case (bus.MemExtOp_M)
                3'd0:       if (byteOff != 2'd0) misaligned = 1'b1;
                3'd3, 3'd4: if (byteOff[0]) misaligned = 1'b1;
                default:    ;
            endcase
        end
    end

    assign addrErr = (bus.MemWrite_M | bus.MemRead_M) & (misaligned | ~inRange);

    always_comb begin
        beRaw    = 4'b0000;
        laneData = 32'h0;
        case (bus.StoreOp_M)
            2'd0: begin
                beRaw    = 4'b1111;
                laneData = bus.WriteData_M;
            end
            2'd1: begin
                beRaw    = byteOff[1] ? 4'b1100 : 4'b0011;
                laneData = {2{bus.WriteData_M[15:0]}};
            end
            2'd2: begin
                beRaw    = 4'b0001 << byteOff;
                laneData = {4{bus.WriteData_M[7:0]}};
            end
            default: ;
        endcase
    end

    assign be            = (bus.MemWrite_M && !addrErr) ? beRaw : 4'b0000;
    assign bus.BE_M      = be;
    assign bus.AddrErr_M = addrErr;

    assign readWord = mem[idx];

    // The write lands on the same edge that captures readWord, so W sees the pre-write value and
    // a load in the following cycle sees the merged word without forwarding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(Words); i++) begin
                mem[i] <= 32'h0;
            end
        end else if (bus.en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= laneData[8*b +: 8];
                end
            end
        end
    end

    logic [31:0] readDataQ;
    logic [1:0]  aQ;
    logic [2:0]  extOpQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readDataQ <= 32'h0;
            aQ        <= 2'd0;
            extOpQ    <= 3'd0;
        end else if (bus.en) begin
            readDataQ <= inRange ? readWord : 32'h0;
            aQ        <= byteOff;
            extOpQ    <= bus.MemExtOp_M;
        end
    end

    assign bus.ReadData_W = readDataQ;
    assign bus.A_W        = aQ;
    assign bus.MemExtOp_W = extOpQ;
endmodule
